// File: rtl/modexp_ctrl_pkg.sv
// Shared state/op encodings and default operand width for the modular exponentiation controller.
package modexp_ctrl_pkg;

    localparam int unsigned DEF_WIDTH = 512;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SCAN  = 3'd1,
        ST_ISSUE = 3'd2,
        ST_WAIT  = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        OP_TOMONT   = 2'd0,
        OP_SQR      = 2'd1,
        OP_MUL      = 2'd2,
        OP_FROMMONT = 2'd3
    } op_e;

endpackage

// File: rtl/modexp_opmux.sv
// Selects the Montgomery multiplier operand pair for the current exponentiation step.
module modexp_opmux
    import modexp_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input  op_e              op_i,
    input  logic [WIDTH-1:0] x_i,
    input  logic [WIDTH-1:0] r2_i,
    input  logic [WIDTH-1:0] acc_i,
    input  logic [WIDTH-1:0] xm_i,
    output logic [WIDTH-1:0] mm_a_c,
    output logic [WIDTH-1:0] mm_b_c
);

    always_comb begin
        mm_a_c = acc_i;
        mm_b_c = acc_i;
        case (op_i)
            OP_TOMONT: begin
                mm_a_c = x_i;
                mm_b_c = r2_i;
            end
            OP_SQR:      ;
            OP_MUL:      mm_b_c = xm_i;
            OP_FROMMONT: mm_b_c = WIDTH'(1);
            default:     ;
        endcase
    end

endmodule

// File: rtl/modexp_ctrl.sv
// Left-to-right binary exponentiation sequencer driving one external Montgomery multiplier.
// Build option MODEXP_SKIP_LEADING_ZEROS_EN adds a SCAN state that skips squarings on leading exponent zeros.
module modexp_ctrl
    import modexp_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH     = DEF_WIDTH,
    parameter int unsigned EXP_WIDTH = DEF_WIDTH
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [WIDTH-1:0]     in_x,
    input  logic [EXP_WIDTH-1:0] in_e,
    input  logic [WIDTH-1:0]     in_m,
    input  logic [WIDTH-1:0]     in_r2,
    input  logic [WIDTH-1:0]     in_rmodm,
    output logic [WIDTH-1:0]     result,
    output logic                 done,
    output logic                 busy,
    output logic                 mm_start,
    output logic [WIDTH-1:0]     mm_a,
    output logic [WIDTH-1:0]     mm_b,
    output logic [WIDTH-1:0]     mm_m,
    input  logic [WIDTH-1:0]     mm_result,
    input  logic                 mm_done
);

    localparam int unsigned      IDX_W   = (EXP_WIDTH > 1) ? $clog2(EXP_WIDTH) : 1;
    localparam logic [IDX_W-1:0] IDX_MSB = IDX_W'(EXP_WIDTH - 1);

    state_e                 state_q, state_d;
    op_e                    op_q, op_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [EXP_WIDTH-1:0]   e_q, e_d;
    logic [WIDTH-1:0]       x_q, x_d, r2_q, r2_d, m_q, m_d;
    logic [WIDTH-1:0]       acc_q, acc_d, xm_q, xm_d;
    logic [WIDTH-1:0]       result_q, result_d, mm_a_q, mm_a_d, mm_b_q, mm_b_d;
    logic                   done_q, done_d, busy_q, busy_d, mm_start_q, mm_start_d;
    logic [WIDTH-1:0]       opmux_a_c, opmux_b_c;

    // Operands are chosen from next-state values so they are registered in the ISSUE cycle.
    modexp_opmux #(.WIDTH(WIDTH)) u_opmux (
        .op_i   (op_d),
        .x_i    (x_d),
        .r2_i   (r2_d),
        .acc_i  (acc_d),
        .xm_i   (xm_d),
        .mm_a_c (opmux_a_c),
        .mm_b_c (opmux_b_c)
    );

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        idx_d   = idx_q;
        e_d     = e_q;
        x_d     = x_q;
        r2_d    = r2_q;
        m_d     = m_q;
        acc_d   = acc_q;
        xm_d    = xm_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    x_d   = in_x;
                    e_d   = in_e;
                    m_d   = in_m;
                    r2_d  = in_r2;
                    acc_d = in_rmodm;
                    idx_d = IDX_MSB;
                    op_d  = OP_TOMONT;
`ifdef MODEXP_SKIP_LEADING_ZEROS_EN
                    state_d = ST_SCAN;
`else
                    state_d = ST_ISSUE;
`endif
                end
            end
`ifdef MODEXP_SKIP_LEADING_ZEROS_EN
            ST_SCAN: begin
                if (!e_q[idx_q] && (idx_q != '0)) begin
                    idx_d = idx_q - IDX_W'(1);
                end else begin
                    state_d = ST_ISSUE;
                end
            end
`endif
            ST_ISSUE: state_d = ST_WAIT;
            ST_WAIT: begin
                if (mm_done) begin
                    state_d = (op_q == OP_FROMMONT) ? ST_DONE : ST_ISSUE;
                    case (op_q)
                        OP_TOMONT: begin
                            xm_d = mm_result;
                            op_d = OP_SQR;
`ifdef MODEXP_SKIP_LEADING_ZEROS_EN
                            if (e_q == '0) op_d = OP_FROMMONT;
`endif
                        end
                        OP_SQR, OP_MUL: begin
                            acc_d = mm_result;
                            if ((op_q == OP_SQR) && e_q[idx_q]) begin
                                op_d = OP_MUL;
                            end else if (idx_q == '0) begin
                                op_d = OP_FROMMONT;
                            end else begin
                                idx_d = idx_q - IDX_W'(1);
                                op_d  = OP_SQR;
                            end
                        end
                        default: acc_d = mm_result;
                    endcase
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Next values of the registered interface outputs, derived from the upcoming state.
    always_comb begin
        mm_start_d = 1'b0;
        mm_a_d     = mm_a_q;
        mm_b_d     = mm_b_q;
        done_d     = 1'b0;
        result_d   = result_q;
        busy_d     = (state_d != ST_IDLE) && (state_d != ST_DONE);
        if (state_d == ST_ISSUE) begin
            mm_start_d = 1'b1;
            mm_a_d     = opmux_a_c;
            mm_b_d     = opmux_b_c;
        end
        if (state_d == ST_DONE) begin
            done_d   = 1'b1;
            result_d = acc_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            op_q       <= OP_TOMONT;
            idx_q      <= '0;
            e_q        <= '0;
            x_q        <= '0;
            r2_q       <= '0;
            m_q        <= '0;
            acc_q      <= '0;
            xm_q       <= '0;
            result_q   <= '0;
            mm_a_q     <= '0;
            mm_b_q     <= '0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
            mm_start_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            idx_q      <= idx_d;
            e_q        <= e_d;
            x_q        <= x_d;
            r2_q       <= r2_d;
            m_q        <= m_d;
            acc_q      <= acc_d;
            xm_q       <= xm_d;
            result_q   <= result_d;
            mm_a_q     <= mm_a_d;
            mm_b_q     <= mm_b_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
            mm_start_q <= mm_start_d;
        end
    end

    assign result   = result_q;
    assign done     = done_q;
    assign busy     = busy_q;
    assign mm_start = mm_start_q;
    assign mm_a     = mm_a_q;
    assign mm_b     = mm_b_q;
    assign mm_m     = m_q;

endmodule
